decode_regfile: RTL and testbench

Parametrised Y86-64 decode/write-back block for the SEQ datapath. It combines the decode source/destination selection (srcA, srcB, dstE, dstM) with an internally owned, clocked register file that has two read ports and two write ports. Compared with the previous decode stage, which only read an externally held register array, this block:
- owns the register state and performs write-back;
- handles the cmovXX condition;
- applies popq %rsp write priority;
- offers optional same-cycle write-to-read bypass.

---
 rtl/y86_pkg.sv | 26 ++
 rtl/regfile_2r2w.sv | 54 +++++
 rtl/decode_regfile.sv | 129 ++++++++++++
 tb/tb_decode_regfile.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, the "no register" specifier and
// the default stack-pointer index, plus a register-index validity helper.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RNONE       = 4'hF;
   localparam int         RSP_DEFAULT = 4;

   // RNONE is never a real register, even if NUM_REGS were raised to 16.
   function automatic logic regValid(input logic [3:0] idx, input int numRegs);
      return (idx != RNONE) && (32'(idx) < numRegs);
   endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// Clocked register file with two read ports, a debug read port and two write
// ports (E and M); M wins when both target the same register.
module regfile_2r2w
   import y86_pkg::*;
#(
   parameter int                DATA_W   = 64,
   parameter int                NUM_REGS = 15,
   parameter int                RSP_IDX  = RSP_DEFAULT,
   parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wbEn,
   input  logic [3:0]        i_addrE,
   input  logic [DATA_W-1:0] i_dataE,
   input  logic [3:0]        i_addrM,
   input  logic [DATA_W-1:0] i_dataM,
   input  logic [3:0]        i_rdAddrA,
   output logic [DATA_W-1:0] o_rdDataA,
   input  logic [3:0]        i_rdAddrB,
   output logic [DATA_W-1:0] o_rdDataB,
   input  logic [3:0]        i_dbgAddr,
   output logic [DATA_W-1:0] o_dbgData
);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic              w_weE;
   logic              w_weM;

   assign w_weE = i_wbEn && regValid(i_addrE, NUM_REGS);
   assign w_weM = i_wbEn && regValid(i_addrM, NUM_REGS);

   // Checking M before E gives popq %rsp its loaded value rather than the increment.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_weM && (i_addrM == 4'(i))) begin
               r_regs[i] <= i_dataM;
            end else if (w_weE && (i_addrE == 4'(i))) begin
               r_regs[i] <= i_dataE;
            end
         end
      end
   end

   assign o_rdDataA = regValid(i_rdAddrA, NUM_REGS) ? r_regs[i_rdAddrA] : '0;
   assign o_rdDataB = regValid(i_rdAddrB, NUM_REGS) ? r_regs[i_rdAddrB] : '0;
   assign o_dbgData = regValid(i_dbgAddr, NUM_REGS) ? r_regs[i_dbgAddr] : '0;

endmodule

// File: rtl/decode_regfile.sv
// SEQ decode / write-back: picks srcA/srcB/dstE/dstM from icode, reads and
// writes the owned register file, and optionally forwards pending writes.
module decode_regfile
   import y86_pkg::*;
#(
   parameter int                DATA_W   = 64,
   parameter int                NUM_REGS = 15,
   parameter int                RSP_IDX  = RSP_DEFAULT,
   parameter logic [DATA_W-1:0] RSP_INIT = '0,
   parameter bit                BYPASS   = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        icode,
   input  logic [3:0]        rA,
   input  logic [3:0]        rB,
   input  logic              cnd,
   input  logic              wb_en,
   input  logic [DATA_W-1:0] valE,
   input  logic [DATA_W-1:0] valM,
   output logic [DATA_W-1:0] valA,
   output logic [DATA_W-1:0] valB,
   output logic [3:0]        dstE,
   output logic [3:0]        dstM,
   input  logic [3:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam logic [3:0] RSP_SEL = RSP_IDX[3:0];

   logic [3:0]        w_srcA;
   logic [3:0]        w_srcB;
   logic [3:0]        w_dstE;
   logic [3:0]        w_dstM;
   logic [DATA_W-1:0] w_rdA;
   logic [DATA_W-1:0] w_rdB;

   always_comb begin
      w_srcA = RNONE;
      w_srcB = RNONE;
      w_dstE = RNONE;
      w_dstM = RNONE;
      case (icode)
         IRRMOVQ: begin
            w_srcA = rA;
            w_dstE = cnd ? rB : RNONE;
         end
         IIRMOVQ: w_dstE = rB;
         IRMMOVQ: begin
            w_srcA = rA;
            w_srcB = rB;
         end
         IMRMOVQ: begin
            w_srcB = rB;
            w_dstM = rA;
         end
         IOPQ: begin
            w_srcA = rA;
            w_srcB = rB;
            w_dstE = rB;
         end
         ICALL: begin
            w_srcB = RSP_SEL;
            w_dstE = RSP_SEL;
         end
         IRET: begin
            w_srcA = RSP_SEL;
            w_srcB = RSP_SEL;
            w_dstE = RSP_SEL;
         end
         IPUSHQ: begin
            w_srcA = rA;
            w_srcB = RSP_SEL;
            w_dstE = RSP_SEL;
         end
         IPOPQ: begin
            w_srcA = RSP_SEL;
            w_srcB = RSP_SEL;
            w_dstE = RSP_SEL;
            w_dstM = rA;
         end
         default: ;
      endcase
   end

   assign dstE = w_dstE;
   assign dstM = w_dstM;

   regfile_2r2w #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .RSP_IDX (RSP_IDX),
      .RSP_INIT(RSP_INIT)
   ) u_regfile (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_wbEn   (wb_en),
      .i_addrE  (w_dstE),
      .i_dataE  (valE),
      .i_addrM  (w_dstM),
      .i_dataM  (valM),
      .i_rdAddrA(w_srcA),
      .o_rdDataA(w_rdA),
      .i_rdAddrB(w_srcB),
      .o_rdDataB(w_rdB),
      .i_dbgAddr(dbg_addr),
      .o_dbgData(dbg_data)
   );

   generate
      if (BYPASS) begin : g_bypass
         logic w_pendE;
         logic w_pendM;

         // A write in a reset cycle is discarded, so it must not be forwarded either.
         assign w_pendE = wb_en && !rst && regValid(w_dstE, NUM_REGS);
         assign w_pendM = wb_en && !rst && regValid(w_dstM, NUM_REGS);

         assign valA = (w_pendM && (w_srcA == w_dstM)) ? valM :
                       (w_pendE && (w_srcA == w_dstE)) ? valE : w_rdA;
         assign valB = (w_pendM && (w_srcB == w_dstM)) ? valM :
                       (w_pendE && (w_srcB == w_dstE)) ? valE : w_rdB;
      end else begin : g_noBypass
         assign valA = w_rdA;
         assign valB = w_rdB;
      end
   endgenerate

endmodule

// File: tb/tb_decode_regfile.sv
// Bench for decode_regfile: a BYPASS=0 and a BYPASS=1 instance share stimulus
// and are compared against an array-based model of the Y86 register rules.
module tb_decode_regfile;

   localparam logic [63:0] RSP_INIT = 64'h100;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  icode, rA, rB, dbgAddr;
   logic        cnd, wbEn;
   logic [63:0] valE, valM;

   logic [63:0] valA0, valB0, dbg0, valA1, valB1, dbg1;
   logic [3:0]  dstE0, dstM0, dstE1, dstM1;

   logic [63:0] model [16];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   decode_regfile #(.DATA_W(64), .NUM_REGS(15), .RSP_IDX(4), .RSP_INIT(RSP_INIT), .BYPASS(1'b0)) dut0 (
      .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd), .wb_en(wbEn),
      .valE(valE), .valM(valM), .valA(valA0), .valB(valB0), .dstE(dstE0), .dstM(dstM0),
      .dbg_addr(dbgAddr), .dbg_data(dbg0));

   decode_regfile #(.DATA_W(64), .NUM_REGS(15), .RSP_IDX(4), .RSP_INIT(RSP_INIT), .BYPASS(1'b1)) dut1 (
      .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd), .wb_en(wbEn),
      .valE(valE), .valM(valM), .valA(valA1), .valB(valB1), .dstE(dstE1), .dstM(dstM1),
      .dbg_addr(dbgAddr), .dbg_data(dbg1));

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic logic [3:0] refSrcA();
      if (icode inside {4'h2, 4'h4, 4'h6, 4'hA}) return rA;
      if (icode inside {4'h9, 4'hB}) return 4'd4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] refSrcB();
      if (icode inside {4'h4, 4'h5, 4'h6}) return rB;
      if (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] refDstE();
      if (icode inside {4'h3, 4'h6}) return rB;
      if (icode == 4'h2) return cnd ? rB : 4'hF;
      if (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] refDstM();
      return (icode inside {4'h5, 4'hB}) ? rA : 4'hF;
   endfunction

   function automatic logic [63:0] refStored(input logic [3:0] idx);
      return (idx < 4'd15) ? model[idx] : 64'd0;
   endfunction

   // What the register would hold after this edge if the write went through.
   function automatic logic [63:0] refForward(input logic [3:0] idx);
      logic [3:0] e, m;
      e = refDstE();
      m = refDstM();
      if (!rst && wbEn && idx < 4'd15) begin
         if (idx == m) return valM;
         if (idx == e) return valE;
      end
      return refStored(idx);
   endfunction

   task automatic resetModel();
      for (int i = 0; i < 16; i++) model[i] = 64'd0;
      model[4] = RSP_INIT;
   endtask

   task automatic driveInputs(input logic r, input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                              input logic c, input logic we, input logic [63:0] e, input logic [63:0] m,
                              input logic [3:0] dbg);
      @(negedge clk);
      rst = r; icode = ic; rA = a; rB = b; cnd = c; wbEn = we; valE = e; valM = m; dbgAddr = dbg;
      #1;
   endtask

   task automatic stepClock();
      logic [3:0] e, m;
      e = refDstE();
      m = refDstM();
      @(posedge clk);
      if (rst) begin
         resetModel();
      end else if (wbEn) begin
         if (e < 4'd15) model[e] = valE;
         if (m < 4'd15) model[m] = valM;
      end
   endtask

   task automatic checkAll();
      checkOutput("dstE0", {60'd0, dstE0}, {60'd0, refDstE()});
      checkOutput("dstM0", {60'd0, dstM0}, {60'd0, refDstM()});
      checkOutput("dstE1", {60'd0, dstE1}, {60'd0, refDstE()});
      checkOutput("dstM1", {60'd0, dstM1}, {60'd0, refDstM()});
      checkOutput("valA0", valA0, refStored(refSrcA()));
      checkOutput("valB0", valB0, refStored(refSrcB()));
      checkOutput("valA1", valA1, refForward(refSrcA()));
      checkOutput("valB1", valB1, refForward(refSrcB()));
      checkOutput("dbg0", dbg0, refStored(dbgAddr));
      checkOutput("dbg1", dbg1, refStored(dbgAddr));
   endtask

   task automatic applyStimulus(input logic r, input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                                input logic c, input logic we, input logic [63:0] e, input logic [63:0] m,
                                input logic [3:0] dbg);
      driveInputs(r, ic, a, b, c, we, e, m, dbg);
      checkAll();
      stepClock();
   endtask

   initial begin
      $display("[TB] decode_regfile bench start");
      driveInputs(1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      stepClock();
      applyStimulus(1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 64'd0, 64'd0, 4'd4);

      // Reset values, then irmovq $5 into reg 3 visible next cycle.
      driveInputs(1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 64'd0, 64'd0, 4'd4);
      checkOutput("rstRsp", dbg0, 64'h100);
      stepClock();
      driveInputs(1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 64'd0, 64'd0, 4'd3);
      checkOutput("rstReg3", dbg0, 64'd0);
      stepClock();
      applyStimulus(1'b0, 4'h3, 4'hF, 4'd3, 1'b0, 1'b1, 64'd5, 64'd0, 4'd3);
      driveInputs(1'b0, 4'h6, 4'd1, 4'd3, 1'b0, 1'b0, 64'd0, 64'd0, 4'd3);
      checkOutput("irmovqValB", valB0, 64'd5);
      stepClock();

      // cmov not taken leaves reg 2 alone; taken writes it.
      driveInputs(1'b0, 4'h2, 4'd1, 4'd2, 1'b0, 1'b1, 64'd7, 64'd0, 4'd2);
      checkOutput("cmovNtDstE", {60'd0, dstE0}, 64'hF);
      stepClock();
      driveInputs(1'b0, 4'h2, 4'd1, 4'd2, 1'b1, 1'b1, 64'd7, 64'd0, 4'd2);
      checkOutput("cmovNtReg2", dbg0, 64'd0);
      stepClock();
      driveInputs(1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 64'd0, 64'd0, 4'd2);
      checkOutput("cmovTkReg2", dbg0, 64'd7);
      stepClock();

      // popq %rsp: valM wins over valE.
      applyStimulus(1'b0, 4'hB, 4'd4, 4'hF, 1'b0, 1'b1, 64'h108, 64'h55, 4'd4);
      driveInputs(1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 64'd0, 64'd0, 4'd4);
      checkOutput("popqRsp", dbg0, 64'h55);
      stepClock();

      // Same-cycle forwarding only on the bypass instance.
      driveInputs(1'b0, 4'h6, 4'd3, 4'd3, 1'b0, 1'b1, 64'd9, 64'd0, 4'd3);
      checkOutput("bypValA", valA1, 64'd9);
      checkOutput("bypValB", valB1, 64'd9);
      checkOutput("noBypValA", valA0, 64'd5);
      checkOutput("noBypDbg", dbg1, 64'd5);
      stepClock();

      // Writes during reset are discarded; mid-program reset restores everything.
      applyStimulus(1'b1, 4'h6, 4'd1, 4'd5, 1'b0, 1'b1, 64'h33, 64'd0, 4'd5);
      driveInputs(1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 64'd0, 64'd0, 4'd5);
      checkOutput("rstWrReg5", dbg0, 64'd0);
      stepClock();
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b0, 4'h3, 4'hF, 4'(i), 1'b0, 1'b1, 64'(i + 64'hA0), 64'd0, 4'(i));
      applyStimulus(1'b1, 4'h3, 4'hF, 4'd1, 1'b0, 1'b1, 64'hBAD, 64'd0, 4'd1);
      for (int i = 0; i < 16; i++)
         applyStimulus(1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 64'd0, 64'd0, 4'(i));

      // RNONE reads zero; a write aimed at index 15 goes nowhere.
      driveInputs(1'b0, 4'h4, 4'hF, 4'd1, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      checkOutput("rnoneValA", valA0, 64'd0);
      stepClock();
      applyStimulus(1'b0, 4'h3, 4'hF, 4'hF, 1'b0, 1'b1, 64'hDEAD, 64'd0, 4'hF);
      driveInputs(1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 64'd0, 64'd0, 4'hF);
      checkOutput("dbg15", dbg0, 64'd0);
      stepClock();

      for (int n = 0; n < 600; n++) begin
         applyStimulus(($urandom_range(0, 31) == 0), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                       {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
